// File: rtl/enable_lock_ctrl.sv
// enable_lock_ctrl: enable/lock gate in front of four DATA_W-bit registers.
// Writes land only while ENABLED. LOCKED is sticky until rst_n.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid             qualifies enable_all / lock_on as a command
//   enable_all, lock_on   decoded requests; lock_on wins when both are set
//   wr_en/wr_addr/wr_data write request
//   rd_addr / rd_data     registered read port, one cycle of latency
//   state_o               00 DISABLED, 01 ENABLED, 10 LOCKED
//   wr_ack / wr_err       one-cycle result pulse for each write
//   viol_cnt              saturating count of cycles with a LOCKED violation
//
// Optional feature: define ENABLE_LOCK_VIOL_CNT_EN to build the violation
// counter. Without it, viol_cnt is tied to zero.
module enable_lock_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic              enable_all,
    input  logic              lock_on,
    input  logic              wr_en,
    input  logic [1:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        state_o,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [3:0]        viol_cnt
);

    localparam logic [1:0] ST_DIS  = 2'b00;
    localparam logic [1:0] ST_EN   = 2'b01;
    localparam logic [1:0] ST_LOCK = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              wr_ack_q, wr_ack_d;
    logic              wr_err_q, wr_err_d;
    logic              wr_ok;

    // Writes are judged against the pre-edge state, so a command in the
    // same cycle cannot open or close the window for that write.
    assign wr_ok = wr_en && (state_q == ST_EN);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_DIS: begin
                if (cmd_valid) begin
                    if (lock_on)
                        state_d = ST_LOCK;
                    else if (enable_all)
                        state_d = ST_EN;
                end
            end
            ST_EN: begin
                if (cmd_valid) begin
                    if (lock_on)
                        state_d = ST_LOCK;
                    else if (!enable_all)
                        state_d = ST_DIS;
                end
            end
            ST_LOCK: state_d = ST_LOCK;
            // The unused encoding fails secure.
            default: state_d = ST_LOCK;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_ok)
            regs_d[wr_addr] = wr_data;
        // Read the pre-edge contents: a same-cycle write is not forwarded.
        rd_data_d = regs_q[rd_addr];
        wr_ack_d  = wr_ok;
        wr_err_d  = wr_en && !wr_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_DIS;
            rd_data_q <= '0;
            wr_ack_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            for (int i = 0; i < 4; i++)
                regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
            wr_ack_q  <= wr_ack_d;
            wr_err_q  <= wr_err_d;
            for (int i = 0; i < 4; i++)
                regs_q[i] <= regs_d[i];
        end
    end

`ifdef ENABLE_LOCK_VIOL_CNT_EN
    logic [3:0] viol_cnt_q, viol_cnt_d;
    logic       locked;
    logic       viol;

    // The unused encoding counts as locked while it recovers.
    assign locked = state_q[1];
    // A command and a write in the same cycle are a single violation.
    assign viol = locked && (cmd_valid || wr_en);

    always_comb begin
        viol_cnt_d = viol_cnt_q;
        if (viol && (viol_cnt_q != 4'hF))
            viol_cnt_d = viol_cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            viol_cnt_q <= 4'd0;
        else
            viol_cnt_q <= viol_cnt_d;
    end

    assign viol_cnt = viol_cnt_q;
`else
    assign viol_cnt = 4'd0;
`endif

    assign state_o = state_q;
    assign rd_data = rd_data_q;
    assign wr_ack  = wr_ack_q;
    assign wr_err  = wr_err_q;

endmodule

// File: doc/enable_lock_ctrl.md
ENABLE_LOCK_CTRL -- requirements
Module: enable_lock_ctrl

Interface
REQ-001 SHALL have parameter: DATA_W, 8, width of each protected register and of wr_data/rd_data.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: cmd_valid  input  1  qualifies enable_all/lock_on as a new command this cycle.
REQ-005 SHALL have port: enable_all  input  1  decoded enable request from the upstream decode_signal stage.
REQ-006 SHALL have port: lock_on  input  1  decoded lock request from the upstream decode_signal stage.
REQ-007 SHALL have port: wr_en  input  1  write request strobe.
REQ-008 SHALL have port: wr_addr  input  2  target register index 0-3.
REQ-009 SHALL have port: wr_data  input  DATA_W  write payload.
REQ-010 SHALL have port: rd_addr  input  2  read register index 0-3.
REQ-011 SHALL have port: rd_data  output  DATA_W  registered read data.
REQ-012 SHALL have port: state_o  output  2  current state: 00 DISABLED, 01 ENABLED, 10 LOCKED.
REQ-013 SHALL have port: wr_ack  output  1  one-cycle pulse, write accepted.
REQ-014 SHALL have port: wr_err  output  1  one-cycle pulse, write rejected.
REQ-015 SHALL have port: viol_cnt  output  4  saturating violation count (see Configuration).

Function
REQ-016 SHALL implement states DISABLED, ENABLED and LOCKED; encoding 11 is unreachable and SHALL recover to LOCKED on the next edge.
REQ-017 DISABLED: cmd_valid with enable_all=1 and lock_on=0 SHALL move to ENABLED; cmd_valid with lock_on=1 SHALL move to LOCKED; all other commands SHALL leave state unchanged.
REQ-018 ENABLED: cmd_valid with lock_on=1 SHALL move to LOCKED; cmd_valid with enable_all=0 and lock_on=0 SHALL move to DISABLED; enable_all=1 and lock_on=0 SHALL hold.
REQ-019 If enable_all and lock_on are both 1 on a valid command, lock_on SHALL take priority (fail-secure).
REQ-020 LOCKED SHALL be sticky; only rst_n SHALL leave it; every cmd_valid in LOCKED SHALL be ignored and counted as a violation.
REQ-021 Commands without cmd_valid SHALL have no effect.
REQ-022 A write SHALL be accepted only when the current (pre-edge) state is ENABLED; the register at wr_addr SHALL update on that edge and wr_ack SHALL pulse on the following cycle.
REQ-023 A write in DISABLED or LOCKED SHALL leave registers unchanged and wr_err SHALL pulse on the following cycle; in LOCKED it SHALL also count as a violation.
REQ-024 With cmd_valid and wr_en in the same cycle, the write SHALL be judged against the state before the transition.
REQ-025 rd_data SHALL present the register at rd_addr one cycle after rd_addr is sampled; a read of the address written in the same cycle SHALL return the old value.
REQ-026 wr_ack and wr_err SHALL never be high together.

Reset
REQ-027 When rst_n is low, state SHALL be DISABLED, all four registers, rd_data and viol_cnt SHALL be 0, and wr_ack/wr_err SHALL be 0, asynchronously.
REQ-028 A reset asserted mid-write SHALL discard the write, with no wr_ack after release.
REQ-029 After release, the first command or write SHALL be evaluated at the first rising edge with rst_n high.

Configuration
REQ-030 Macro ENABLE_LOCK_VIOL_CNT_EN defined: viol_cnt SHALL increment by 1 per violation-cycle (one increment even if command and write both violate), saturating at 15.
REQ-031 Macro undefined: no counter logic SHALL exist and viol_cnt SHALL be tied to 0; all other behaviour SHALL be identical.

Verification
REQ-032 After reset, write 0xA5 to addr 1 -> wr_err pulses, rd_data for addr 1 reads 0x00.
REQ-033 With cmd_valid and enable_all=1, write 0x3C to addr 2, then read addr 2 -> state_o=01, wr_ack pulses, rd_data=0x3C one cycle after rd_addr.
REQ-034 From ENABLED, apply cmd_valid with lock_on=1 and the same cycle write 0x77 to addr 0 -> write accepted (wr_ack), state_o=10; a subsequent enable command leaves state_o=10.
REQ-035 In LOCKED, issue 20 rejected writes -> 20 wr_err pulses and, with macro defined, viol_cnt=15 (saturated); with macro undefined, viol_cnt=0.
REQ-036 Apply cmd_valid with enable_all=1 and lock_on=1 from DISABLED -> state_o=10.
REQ-037 Assert rst_n low asynchronously while in LOCKED with registers nonzero -> state_o=00 and all registers read 0x00 immediately after reset.
